// File: rtl/matrix_tile_streamer_pkg.sv
// Shared types and constants for the matrix tile streamer: element type,
// tile-order encoding and FSM state encoding.
package mat_pkg;

  localparam int ELEM_W = 16;
  typedef logic signed [ELEM_W-1:0] elem_t;

  localparam logic ORDER_COL = 1'b0;
  localparam logic ORDER_ROW = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter width for a range of nt values; a lone value still gets one bit.
  function automatic int cw_of(input int nt);
    return (nt > 1) ? $clog2(nt) : 1;
  endfunction

endpackage

// File: rtl/matrix_tile_streamer_tile_extract.sv
// Combinational TxT tile selector: picks tile (tr, tc) out of a packed NxN
// matrix by pure bit selection.
module tile_extract
  import mat_pkg::*;
#(
  parameter int DW = 16,
  parameter int N  = 64,
  parameter int T  = 16,
  parameter int CW = cw_of(N / T)
) (
  input  logic [N*N*DW-1:0] i_matrix,
  input  logic [CW-1:0]     i_tr,
  input  logic [CW-1:0]     i_tc,
  output logic [T*T*DW-1:0] o_tile
);

  logic [31:0] w_row0;
  logic [31:0] w_col0;

  assign w_row0 = 32'(i_tr) * 32'(T);
  assign w_col0 = 32'(i_tc) * 32'(T);

  for (genvar i = 0; i < T; i++) begin : g_row
    for (genvar j = 0; j < T; j++) begin : g_col
      assign o_tile[(i*T+j)*DW +: DW] =
        i_matrix[((w_row0 + i) * N + w_col0 + j) * DW +: DW];
    end
  end

endmodule

// File: rtl/matrix_tile_streamer.sv
// Captures an NxN matrix on start and streams its TxT tiles over a
// valid/ready port in column-group-major or row-group-major order.
module matrix_tile_streamer
  import mat_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int N     = 64,
  parameter  int T     = 16,
  localparam int NT    = N / T,
  localparam int NTILE = NT * NT,
  localparam int CW    = cw_of(NT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              order,
  input  logic [N*N*DW-1:0] matrix,
  output logic [T*T*DW-1:0] tile_data,
  output logic [CW-1:0]     tile_row,
  output logic [CW-1:0]     tile_col,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              tile_last,
  output logic              busy,
  output logic              done
);

  localparam int IW = cw_of(NTILE);
  localparam logic [CW-1:0] LAST_CRD = CW'(NT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTILE - 1);

  if (N % T != 0) begin : g_bad_tile
    $error("matrix_tile_streamer: N must be a multiple of T");
  end

  state_t              r_state;
  logic [N*N*DW-1:0]   r_mat;
  logic                r_order;
  logic [CW-1:0]       r_tr;
  logic [CW-1:0]       r_tc;
  logic [IW-1:0]       r_idx;
  logic [T*T*DW-1:0]   r_tile_data;
  logic [CW-1:0]       r_tile_row;
  logic [CW-1:0]       r_tile_col;
  logic                r_tile_valid;
  logic                r_tile_last;
  logic                r_busy;
  logic                r_done;

  logic [T*T*DW-1:0]   w_tile;
  logic [CW-1:0]       w_adv_tr;
  logic [CW-1:0]       w_adv_tc;
  logic                w_load;

  // r_tr/r_tc always name the next tile to be loaded, not the presented one.
  tile_extract #(
    .DW(DW),
    .N (N),
    .T (T),
    .CW(CW)
  ) u_extract (
    .i_matrix(r_mat),
    .i_tr    (r_tr),
    .i_tc    (r_tc),
    .o_tile  (w_tile)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_adv_tr = r_tr;
    w_adv_tc = r_tc;
    case (r_order)
      ORDER_COL: begin
        if (r_tr == LAST_CRD) begin
          w_adv_tr = '0;
          w_adv_tc = (r_tc == LAST_CRD) ? '0 : r_tc + 1'b1;
        end else begin
          w_adv_tr = r_tr + 1'b1;
        end
      end
      ORDER_ROW: begin
        if (r_tc == LAST_CRD) begin
          w_adv_tc = '0;
          w_adv_tr = (r_tr == LAST_CRD) ? '0 : r_tr + 1'b1;
        end else begin
          w_adv_tc = r_tc + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_load = (r_state == ST_LOAD) ||
                  ((r_state == ST_STREAM) && r_tile_valid && tile_ready && !r_tile_last);

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      // NOTE: the capture store is reset too, so a fresh part never exposes stale data.
      r_mat        <= '0;
      r_order      <= ORDER_COL;
      r_tr         <= '0;
      r_tc         <= '0;
      r_idx        <= '0;
      r_tile_data  <= '0;
      r_tile_row   <= '0;
      r_tile_col   <= '0;
      r_tile_valid <= 1'b0;
      r_tile_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mat   <= matrix;
            r_order <= order;
            r_tr    <= '0;
            r_tc    <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tile_valid <= 1'b1;
          r_state      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (r_tile_valid && tile_ready && r_tile_last) begin
            r_tile_valid <= 1'b0;
            r_tile_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_load) begin
        r_tile_data <= w_tile;
        r_tile_row  <= r_tr;
        r_tile_col  <= r_tc;
        r_tile_last <= (r_idx == LAST_IDX);
        r_idx       <= r_idx + 1'b1;
        r_tr        <= w_adv_tr;
        r_tc        <= w_adv_tc;
      end
    end
  end

  assign tile_data  = r_tile_data;
  assign tile_row   = r_tile_row;
  assign tile_col   = r_tile_col;
  assign tile_valid = r_tile_valid;
  assign tile_last  = r_tile_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_matrix_tile_streamer.sv
// Scoreboard bench for matrix_tile_streamer: small ramp configs, a single-tile
// config and the default 64x64/16x16 config with backpressure and reset.
module tb_matrix_tile_streamer;
  import mat_pkg::*;

  typedef struct {
    int              tr;
    int              tc;
    bit              last;
    logic [4095:0]   data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, order, ready;
  int   sel;
  logic [127:0]   m_s;
  logic [65535:0] m_b;

  int tests = 0;
  int fails = 0;
  exp_t          exp_q[$];
  logic [4095:0] rx_q[$];

  // small: N=4 T=2 DW=8
  logic s_start, s_ready, s_valid, s_last, s_busy, s_done;
  logic [31:0] s_data;
  logic [0:0]  s_row, s_col;
  // single tile: N=4 T=4 DW=8
  logic o_start, o_ready, o_valid, o_last, o_busy, o_done;
  logic [127:0] o_data;
  logic [0:0]   o_row, o_col;
  // default: N=64 T=16 DW=16
  logic b_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [4095:0] b_data;
  logic [1:0]    b_row, b_col;

  assign s_start = start && (sel == 0);
  assign s_ready = ready && (sel == 0);
  assign o_start = start && (sel == 1);
  assign o_ready = ready && (sel == 1);
  assign b_start = start && (sel == 2);
  assign b_ready = ready && (sel == 2);

  matrix_tile_streamer #(.DW(8), .N(4), .T(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .order(order), .matrix(m_s),
    .tile_data(s_data), .tile_row(s_row), .tile_col(s_col), .tile_valid(s_valid),
    .tile_ready(s_ready), .tile_last(s_last), .busy(s_busy), .done(s_done));

  matrix_tile_streamer #(.DW(8), .N(4), .T(4)) u_one (
    .clk(clk), .rst(rst), .start(o_start), .order(order), .matrix(m_s),
    .tile_data(o_data), .tile_row(o_row), .tile_col(o_col), .tile_valid(o_valid),
    .tile_ready(o_ready), .tile_last(o_last), .busy(o_busy), .done(o_done));

  matrix_tile_streamer u_big (
    .clk(clk), .rst(rst), .start(b_start), .order(order), .matrix(m_b),
    .tile_data(b_data), .tile_row(b_row), .tile_col(b_col), .tile_valid(b_valid),
    .tile_ready(b_ready), .tile_last(b_last), .busy(b_busy), .done(b_done));

  logic          obs_valid, obs_last, obs_busy, obs_done;
  int            obs_row, obs_col;
  logic [4095:0] obs_data;

  always_comb begin
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    obs_busy  = 1'b0;
    obs_done  = 1'b0;
    obs_row   = 0;
    obs_col   = 0;
    obs_data  = '0;
    case (sel)
      0: begin
        obs_valid = s_valid; obs_last = s_last; obs_busy = s_busy; obs_done = s_done;
        obs_row = int'(s_row); obs_col = int'(s_col); obs_data[31:0] = s_data;
      end
      1: begin
        obs_valid = o_valid; obs_last = o_last; obs_busy = o_busy; obs_done = o_done;
        obs_row = int'(o_row); obs_col = int'(o_col); obs_data[127:0] = o_data;
      end
      default: begin
        obs_valid = b_valid; obs_last = b_last; obs_busy = b_busy; obs_done = b_done;
        obs_row = int'(b_row); obs_col = int'(b_col); obs_data = b_data;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
    int idx = -1;
    int w;
    for (int k = 0; k < 256; k++)
      if (idx < 0 && got[k*16 +: 16] !== exp[k*16 +: 16]) idx = k;
    w = (idx < 0) ? 0 : idx;
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: word %0d observed %h expected %h", tag, idx, got[w*16 +: 16], exp[w*16 +: 16]);
    end
  endtask

  // Expected tile sequence for one pass, straight from the element-mapping formula.
  task automatic push_pass(input int n, input int t, input int dw, input bit ord,
                           input logic [65535:0] m);
    int   nt = n / t;
    int   tr, tc;
    exp_t e;
    for (int k = 0; k < nt * nt; k++) begin
      if (ord == 1'b0) begin tc = k / nt; tr = k % nt; end
      else begin tr = k / nt; tc = k % nt; end
      e.tr = tr;
      e.tc = tc;
      e.last = (k == nt * nt - 1);
      e.data = '0;
      for (int i = 0; i < t; i++)
        for (int j = 0; j < t; j++)
          for (int b = 0; b < dw; b++)
            e.data[(i*t+j)*dw + b] = m[((tr*t+i)*n + tc*t + j)*dw + b];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input string name, input bit ord);
    order = ord;
    ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " load busy"}, obs_busy, 1);
    check({name, " load valid"}, obs_valid, 0);
    @(posedge clk); #1;
    check({name, " first valid at k+2"}, obs_valid, 1);
  endtask

  task automatic run_pass(input string name, input int budget, input bit bp,
                          input int start_cyc, input int stop_after);
    int            cyc = 0;
    int            acc = 0;
    bit            fin = 1'b0;
    bit            want_done = 1'b0;
    bit            stalled = 1'b0;
    int            s_r = 0;
    int            s_c = 0;
    bit            s_l = 1'b0;
    logic [4095:0] s_d = '0;
    exp_t          e;
    while (!fin && cyc < budget) begin
      start = (cyc == start_cyc);
      ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (want_done) begin
        check({name, " done pulse"}, obs_done, 1);
        check({name, " valid low after last"}, obs_valid, 0);
        check({name, " busy low in done"}, obs_busy, 0);
        fin = 1'b1;
      end else if (stop_after > 0 && acc == stop_after) begin
        fin = 1'b1;
      end else begin
        check({name, " no early done"}, obs_done, 0);
        if (stalled) begin
          check({name, " stall valid"}, obs_valid, 1);
          check({name, " stall row"}, obs_row, s_r);
          check({name, " stall col"}, obs_col, s_c);
          check({name, " stall last"}, obs_last, s_l);
          check_data({name, " stall data"}, obs_data, s_d);
          stalled = 1'b0;
        end
        if (obs_valid && ready) begin
          check({name, " tile expected"}, exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s tile%0d row", name, acc), obs_row, e.tr);
            check($sformatf("%s tile%0d col", name, acc), obs_col, e.tc);
            check($sformatf("%s tile%0d last", name, acc), obs_last, e.last);
            check_data($sformatf("%s tile%0d data", name, acc), obs_data, e.data);
            rx_q.push_back(obs_data);
            acc++;
            want_done = e.last;
          end
        end else if (obs_valid) begin
          s_r = obs_row; s_c = obs_col; s_l = obs_last; s_d = obs_data;
          stalled = 1'b1;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({name, " finished within budget"}, fin, 1);
    if (stop_after == 0) begin
      @(posedge clk); #1;
      check({name, " done is one cycle"}, obs_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; order = 1'b0; ready = 1'b0; sel = 0;
    m_s = '0; m_b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check($sformatf("reset%0d valid", k), obs_valid, 0);
      check($sformatf("reset%0d busy", k), obs_busy, 0);
      check($sformatf("reset%0d done", k), obs_done, 0);
      check($sformatf("reset%0d last", k), obs_last, 0);
      check($sformatf("reset%0d row", k), obs_row, 0);
      check($sformatf("reset%0d col", k), obs_col, 0);
      check_data($sformatf("reset%0d data", k), obs_data, '0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp 4x4, both orders
    sel = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_s[(r*4+c)*8 +: 8] = 8'(r*4 + c);
    rx_q.delete();
    push_pass(4, 2, 8, 1'b0, m_s);
    do_start("ramp col", 1'b0);
    run_pass("ramp col", 50, 1'b0, -1, 0);
    check("ramp col count", rx_q.size(), 4);
    check("ramp col tile(1,0)", rx_q[1][31:0], 32'h0D0C0908);

    rx_q.delete();
    push_pass(4, 2, 8, 1'b1, m_s);
    do_start("ramp row", 1'b1);
    run_pass("ramp row", 50, 1'b0, -1, 0);
    check("ramp row count", rx_q.size(), 4);
    check("ramp row tile(0,1)", rx_q[1][31:0], 32'h07060302);

    // Single tile (T = N)
    sel = 1;
    rx_q.delete();
    push_pass(4, 4, 8, 1'b0, m_s);
    do_start("nt1", 1'b0);
    run_pass("nt1", 20, 1'b0, -1, 0);
    check("nt1 count", rx_q.size(), 1);

    // start mid-stream with a new matrix and order is ignored
    sel = 0;
    rx_q.delete();
    push_pass(4, 2, 8, 1'b0, m_s);
    do_start("ignore", 1'b0);
    m_s = ~m_s;
    order = 1'b1;
    run_pass("ignore start", 50, 1'b0, 1, 0);
    check("ignore count", rx_q.size(), 4);
    rx_q.delete();
    push_pass(4, 2, 8, 1'b1, m_s);
    do_start("second pass", 1'b1);
    run_pass("second pass", 50, 1'b0, -1, 0);

    // Default config with backpressure 1,0,0,1
    sel = 2;
    for (int k = 0; k < 2048; k++) m_b[k*32 +: 32] = $urandom();
    rx_q.delete();
    push_pass(64, 16, 16, 1'b0, m_b);
    do_start("bp", 1'b0);
    run_pass("bp", 400, 1'b1, -1, 0);
    check("bp count", rx_q.size(), 16);
    check("bp tile(3,3) elem(15,15)", rx_q[15][4095:4080], m_b[65535:65520]);

    // Signed data
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        elem_t v;
        v = elem_t'(-(r*64 + c));
        m_b[(r*64+c)*16 +: 16] = v;
      end
    rx_q.delete();
    push_pass(64, 16, 16, 1'b1, m_b);
    do_start("signed", 1'b1);
    run_pass("signed", 100, 1'b0, -1, 0);
    check("signed tile(2,1) elem(0,0)", rx_q[9][15:0], 16'hF7F0);

    // Asynchronous reset after five accepted tiles
    rx_q.delete();
    push_pass(64, 16, 16, 1'b0, m_b);
    do_start("rst", 1'b0);
    run_pass("rst partial", 100, 1'b0, -1, 5);
    #2;
    rst = 1'b1;
    #1;
    check("rst valid", obs_valid, 0);
    check("rst busy", obs_busy, 0);
    check("rst done", obs_done, 0);
    check("rst last", obs_last, 0);
    check("rst row", obs_row, 0);
    check("rst col", obs_col, 0);
    check_data("rst data", obs_data, '0);
    #2;
    rst = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post rst%0d done", k), obs_done, 0);
      check($sformatf("post rst%0d valid", k), obs_valid, 0);
    end
    exp_q.delete();
    rx_q.delete();
    push_pass(64, 16, 16, 1'b0, m_b);
    do_start("after rst", 1'b0);
    run_pass("after rst", 100, 1'b0, -1, 0);
    check("after rst count", rx_q.size(), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_tile_streamer.md
Name: matrix_tile_streamer

Overview:
- Parametrised successor to the fixed 64x64 to sixteen 16x16 tile selector.
- Captures one NxN matrix of signed DW-bit elements on a start strobe, then streams its (N/T)^2 TxT tiles one per handshake.
- Uses a valid/ready output, a selectable tile order, tile coordinates and a completion pulse.
- Sits between the matrix source and the PE array feeder. It replaces the 16-wide parallel output bus with a single tile port.

Parameters:
- DW, 16, element width in bits (signed two's complement).
- N, 64, matrix dimension (rows = cols).
- T, 16, tile dimension. N mod T must be 0; elaboration-time error otherwise.
- Derived, not overridable: NT = N/T; NTILE = NT*NT; CW = max(1, clog2(NT)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- start  in  1  capture matrix and begin a pass; honoured only in IDLE.
- order  in  1  0 = column-group-major, 1 = row-group-major; sampled with start.
- matrix  in  N*N*DW  element (r,c) at bits [(r*N+c)*DW +: DW].
- tile_data  out  T*T*DW  element (i,j) at [(i*T+j)*DW +: DW] = matrix(tr*T+i, tc*T+j).
- tile_row  out  CW  tr of current tile.
- tile_col  out  CW  tc of current tile.
- tile_valid  out  1  tile_data/tile_row/tile_col/tile_last valid.
- tile_ready  in  1  consumer accepts when tile_valid & tile_ready.
- tile_last  out  1  high with the final tile of the pass.
- busy  out  1  high in LOAD and STREAM.
- done  out  1  one-cycle pulse after the last tile is accepted.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all outputs 0. State = IDLE, counters 0, captured matrix 0.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start=1 registers matrix and order into internal storage, clears tr/tc, goes to LOAD.
  - start=0 holds; tile_valid=0.
- LOAD (1 cycle): computes tile (0,0) into the tile_data register; sets tile_valid=1 and busy=1; goes to STREAM.
  - Latency is start (cycle k) to tile_valid (cycle k+2).
- STREAM, tile order:
  - order=0: tc outer, tr inner, so the sequence is (0,0),(1,0),...,(NT-1,0),(0,1),...
  - order=1: tr outer, tc inner.
- STREAM, stall: while tile_valid & !tile_ready, all tile outputs hold bit-stable.
- STREAM, accept of a non-last tile: the next tile is presented the following cycle with tile_valid still 1. Full throughput is one tile per cycle under continuous ready.
- tile_last = 1 exactly when the presented tile is index NTILE-1: (NT-1,NT-1) in both orders.
- Accept of the last tile: tile_valid drops to 0 next cycle; state goes to DONE.
- DONE (1 cycle): done=1, busy=0. Then IDLE.
  - start is ignored in DONE.
  - start in the cycle after DONE begins a new pass.
- start during LOAD, STREAM or DONE is ignored. Captured storage and order are unchanged mid-pass.
- The matrix input may change after the capture cycle; output reflects captured data only.
- tile_ready with tile_valid=0 has no effect.
- NT=1 (T=N): a single tile with tile_last=1; done follows its accept.
- Asynchronous rst mid-pass: immediate return to reset values. Any in-flight tile is dropped with no done pulse.
- Data is pure bit selection: no sign extension or arithmetic. Signed values pass unchanged.

Decomposition:
- Shared package mat_pkg holds:
  - the elem_t typedef (signed [DW-1:0]);
  - ORDER_COL=1'b0 and ORDER_ROW=1'b1;
  - the state encoding.
- Sub-module tile_extract (combinational):
  - inputs: captured matrix, tr, tc; output: the T*T*DW tile, via generate loops over i and j.
  - Top-level FSM, counters and output register live in matrix_tile_streamer.

Test Plan:
- Ramp, N=4, T=2, DW=8. matrix(r,c)=r*4+c, order=0, ready always 1.
  - Tiles (tr,tc) arrive in order (0,0),(1,0),(0,1),(1,1).
  - Tile (1,0) elements = {8,9,12,13}.
  - tile_last on the 4th tile; done 1 cycle later; first valid 2 cycles after start.
- Same matrix, order=1. Sequence (0,0),(0,1),(1,0),(1,1); tile (0,1) = {2,3,6,7}.
- Backpressure, defaults (N=64, T=16, DW=16), ready toggled 1,0,0,1.
  - All 16 tiles delivered exactly once; outputs stable during stalls.
  - Tile (3,3) element (15,15) = matrix(63,63).
- Signed data: matrix(r,c) = -(r*64+c) at DW=16. Tile (2,1) element (0,0) = 16'hF7F0 (-2064).
- start pulsed in STREAM with a different matrix: ignored; the original tiles continue; a second start after done streams the new matrix.
- rst asserted asynchronously after tile 5 is accepted: tile_valid, busy and done go to 0 immediately, with no done pulse. A subsequent start streams from (0,0).
